// File: rtl/cpu_move_selector.sv
// ---------------------------------------------------------------------------
// cpu_move_selector
//
// Chooses the CPU's move for one battle turn. The block classifies the
// battle into a strategy mode from both sides' HP, then scans every move
// slot. For each slot it asks the shared damage calculator for damage and
// accuracy over a req/valid handshake, and it keeps the best-scoring
// eligible slot. It reports the winner with a one-cycle done pulse, then
// waits for the battle FSM to drop CPU_turn before it can be re-armed.
//
// Optional feature macro: AI_PP_CHECK_EN
//   defined   : slots whose remaining PP is zero are ineligible
//   undefined : pp is accepted but ignored; eligibility is damage != 0
//
// Parameters
//   NUM_MOVES  number of move slots scanned (>= 2)
//   HP_W       HP field width
//   DMG_W      damage width
//   ACC_W      accuracy width (0..100 in use)
//   LOW_PCT    finish-mode threshold, percent of max HP
//   HIGH_PCT   aggressive-mode threshold, percent of CPU max HP
//
// Ports
//   Clk, Reset             clock, synchronous active-high reset
//   CPU_turn               level start request, sampled in IDLE
//   player_hp/_max_hp      player HP and max HP
//   CPU_hp/CPU_max_hp      CPU HP and max HP
//   pp                     remaining PP of slot move_idx
//   dmg_req, move_idx      damage request and the slot under evaluation
//   dmg_valid, damage,
//   accuracy               calculator response for move_idx
//   move, no_move          selected slot / no eligible slot (registered)
//   mode                   latched strategy: 0 BALANCED, 1 AGGRESSIVE, 2 FINISH
//   CPU_done               one-cycle completion pulse
// ---------------------------------------------------------------------------
module cpu_move_selector #(
  parameter int unsigned NUM_MOVES = 4,
  parameter int unsigned HP_W      = 8,
  parameter int unsigned DMG_W     = 8,
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned LOW_PCT   = 20,
  parameter int unsigned HIGH_PCT  = 90,
  localparam int unsigned IW       = $clog2(NUM_MOVES)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CPU_turn,
  input  logic [HP_W-1:0]  player_hp,
  input  logic [HP_W-1:0]  player_max_hp,
  input  logic [HP_W-1:0]  CPU_hp,
  input  logic [HP_W-1:0]  CPU_max_hp,
  input  logic [7:0]       pp,
  output logic             dmg_req,
  output logic [IW-1:0]    move_idx,
  input  logic             dmg_valid,
  input  logic [DMG_W-1:0] damage,
  input  logic [ACC_W-1:0] accuracy,
  output logic [IW-1:0]    move,
  output logic [1:0]       mode,
  output logic             no_move,
  output logic             CPU_done
);

  // HP*100 needs 7 extra bits; the balanced score needs the full product
  localparam int unsigned PW = HP_W + 7;
  localparam int unsigned SW = DMG_W + ACC_W;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MOVES - 1);
  localparam logic [PW-1:0] K_100    = PW'(100);
  localparam logic [PW-1:0] K_LOW    = PW'(LOW_PCT);
  localparam logic [PW-1:0] K_HIGH   = PW'(HIGH_PCT);

  localparam logic [1:0] MODE_BAL = 2'd0;
  localparam logic [1:0] MODE_AGG = 2'd1;
  localparam logic [1:0] MODE_FIN = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_REQ,
    S_DONE,
    S_WAIT_LOW
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    move_idx_n;
  logic [IW-1:0]    best_idx, best_idx_n;
  logic [DMG_W-1:0] best_dmg, best_dmg_n;
  logic [ACC_W-1:0] best_acc, best_acc_n;
  logic             found, found_n;
  logic [IW-1:0]    move_n;
  logic [1:0]       mode_n;
  logic             no_move_n;
  logic             cpu_done_n;
  logic             dmg_req_n;

  // Strategy classification by cross-multiplication (no dividers)
  logic [PW-1:0] player_x100, player_low_lim;
  logic [PW-1:0] cpu_x100, cpu_low_lim, cpu_high_lim;
  logic          player_low, cpu_low, cpu_high, max_zero;
  logic [1:0]    mode_class;

  always_comb begin
    player_x100    = PW'(player_hp) * K_100;
    player_low_lim = PW'(player_max_hp) * K_LOW;
    cpu_x100       = PW'(CPU_hp) * K_100;
    cpu_low_lim    = PW'(CPU_max_hp) * K_LOW;
    cpu_high_lim   = PW'(CPU_max_hp) * K_HIGH;

    player_low = (player_x100 < player_low_lim);
    cpu_low    = (cpu_x100 < cpu_low_lim);
    cpu_high   = (cpu_x100 >= cpu_high_lim);
    max_zero   = (player_max_hp == '0) || (CPU_max_hp == '0);

    mode_class = MODE_BAL;
    if (max_zero) begin
      mode_class = MODE_BAL;
    end else if (player_low || cpu_low) begin
      mode_class = MODE_FIN;
    end else if (cpu_high) begin
      mode_class = MODE_AGG;
    end
  end

  // PP gating of eligibility
  logic pp_ok;
`ifdef AI_PP_CHECK_EN
  assign pp_ok = (pp != 8'd0);
`else
  logic unused_pp;
  assign unused_pp = &{1'b0, pp};
  assign pp_ok     = 1'b1;
`endif

  // Score comparison of the responding slot against the current best
  logic [SW-1:0] cand_score, best_score;
  logic          eligible, better, take;

  always_comb begin
    cand_score = SW'(damage) * SW'(accuracy);
    best_score = SW'(best_dmg) * SW'(best_acc);
    eligible   = (damage != '0) && pp_ok;

    better = 1'b0;
    case (mode)
      MODE_FIN: better = (accuracy > best_acc);
      MODE_AGG: better = (damage > best_dmg);
      default:  better = (cand_score > best_score);
    endcase

    // strict comparison keeps the lower index on ties
    take = eligible && (!found || better);
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      move_idx <= '0;
      best_idx <= '0;
      best_dmg <= '0;
      best_acc <= '0;
      found    <= 1'b0;
      move     <= '0;
      mode     <= MODE_BAL;
      no_move  <= 1'b0;
      CPU_done <= 1'b0;
      dmg_req  <= 1'b0;
    end else begin
      state    <= state_n;
      move_idx <= move_idx_n;
      best_idx <= best_idx_n;
      best_dmg <= best_dmg_n;
      best_acc <= best_acc_n;
      found    <= found_n;
      move     <= move_n;
      mode     <= mode_n;
      no_move  <= no_move_n;
      CPU_done <= cpu_done_n;
      dmg_req  <= dmg_req_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    move_idx_n = move_idx;
    best_idx_n = best_idx;
    best_dmg_n = best_dmg;
    best_acc_n = best_acc;
    found_n    = found;
    move_n     = move;
    mode_n     = mode;
    no_move_n  = no_move;
    cpu_done_n = 1'b0;
    dmg_req_n  = 1'b0;

    unique case (state)
      S_IDLE: begin
        best_idx_n = '0;
        best_dmg_n = '0;
        best_acc_n = '0;
        found_n    = 1'b0;
        if (CPU_turn) begin
          state_n = S_CLASSIFY;
        end
      end

      S_CLASSIFY: begin
        mode_n     = mode_class;
        move_idx_n = '0;
        dmg_req_n  = 1'b1;
        state_n    = S_REQ;
      end

      S_REQ: begin
        dmg_req_n = 1'b1;
        if (dmg_valid) begin
          if (take) begin
            best_idx_n = move_idx;
            best_dmg_n = damage;
            best_acc_n = accuracy;
            found_n    = 1'b1;
          end
          if (move_idx == LAST_IDX) begin
            // result registers load with the last slot already folded in,
            // so they are valid in the same cycle as the done pulse
            dmg_req_n  = 1'b0;
            cpu_done_n = 1'b1;
            move_n     = found_n ? best_idx_n : '0;
            no_move_n  = !found_n;
            state_n    = S_DONE;
          end else begin
            move_idx_n = move_idx + IW'(1);
          end
        end
      end

      S_DONE: begin
        state_n = S_WAIT_LOW;
      end

      S_WAIT_LOW: begin
        // hold off re-triggering until the battle FSM releases the turn
        if (!CPU_turn) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
